// File: rtl/spi_matrix_tx_pkg.sv
// Shared types and width helpers for the multi-channel SPI matrix transmitter.
package spi_matrix_tx_pkg;

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHIFT} state_t;
    typedef enum logic [1:0] {DATA, COLUMN, IMAGE} kind_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_matrix_tx_sclk_gen.sv
// SCLK generator: half-period counter with fall/rise ticks, runs only when enabled.
module spi_tx_sclk_gen
    import spi_matrix_tx_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_en,
    output logic O_sclk,
    output logic O_fall_tick,
    output logic O_rise_tick
);

    localparam int HW = cnt_w(CLK_DIV);
    localparam logic [HW-1:0] LAST = HW'(CLK_DIV - 1);

    logic [HW-1:0] cnt;
    logic          term;

    assign term        = I_en && (cnt == LAST);
    assign O_rise_tick = term && !O_sclk;
    assign O_fall_tick = term && O_sclk;

    always_ff @(posedge I_clk) begin
        if (I_rst || !I_en) begin
            cnt    <= '0;
            O_sclk <= 1'b0;
        end else if (term) begin
            cnt    <= '0;
            O_sclk <= ~O_sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_matrix_tx.sv
// Parallel multi-channel SPI transmitter with column/image CS gaps.
// Optional idle CS release: define SPI_MATRIX_TX_CS_TIMEOUT_EN.
module spi_matrix_tx
    import spi_matrix_tx_pkg::*;
#(
    parameter int SPI_CHANNEL_NUMBER = 4,
    parameter int DATA_WIDTH         = 8,
    parameter int CLK_DIV            = 2,
    parameter int COLUMN_GAP         = 8,
    parameter int IMAGE_GAP          = 32,
    parameter int CS_TIMEOUT_CYCLES  = 256
) (
    input  logic                                     I_clk,
    input  logic                                     I_rst,
    input  logic                                     I_next_data,
    input  logic                                     I_next_column,
    input  logic                                     I_next_image,
    input  logic [SPI_CHANNEL_NUMBER*DATA_WIDTH-1:0] I_data_flat,
    output logic                                     O_tx_finish,
    output logic                                     O_spi_sclk,
    output logic                                     O_spi_cs_n,
    output logic [SPI_CHANNEL_NUMBER-1:0]            O_spi_mosi,
    output logic                                     O_overrun
);

    localparam int N  = SPI_CHANNEL_NUMBER;
    localparam int W  = DATA_WIDTH;
    localparam int BW = idx_w(W);
    localparam int GW = cnt_w(max_int(IMAGE_GAP, COLUMN_GAP));
    localparam logic [GW-1:0] IMG_GAP = GW'(IMAGE_GAP);
    localparam logic [GW-1:0] COL_GAP = GW'(COLUMN_GAP);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    state_t         state;
    kind_t          kind;
    logic [N*W-1:0] shreg, shl;
    logic [N-1:0]   nxt_msb, sh_msb, in_msb;
    logic [BW-1:0]  bcnt;
    logic [GW-1:0]  gcnt;
    logic           last;
    logic           any_pulse;
    logic           fall_tick, rise_tick;

`ifdef SPI_MATRIX_TX_CS_TIMEOUT_EN
    localparam int TW = cnt_w(CS_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(CS_TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_cnt;
`endif

    assign any_pulse = I_next_data | I_next_column | I_next_image;

    always_comb begin
        kind = DATA;
        unique case (1'b1)
            I_next_image:                  kind = IMAGE;
            I_next_column && !I_next_image: kind = COLUMN;
            default:                       kind = DATA;
        endcase
    end

    always_comb begin
        shl     = '0;
        nxt_msb = '0;
        sh_msb  = '0;
        in_msb  = '0;
        for (int i = 0; i < N; i++) begin
            shl[i*W +: W] = {shreg[i*W +: W-1], 1'b0};
            nxt_msb[i]    = shreg[i*W + W - 2];
            sh_msb[i]     = shreg[i*W + W - 1];
            in_msb[i]     = I_data_flat[i*W + W - 1];
        end
    end

    spi_tx_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_en       (state == S_SHIFT),
        .O_sclk     (O_spi_sclk),
        .O_fall_tick(fall_tick),
        .O_rise_tick(rise_tick)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bcnt        <= '0;
            gcnt        <= '0;
            last        <= 1'b0;
            O_tx_finish <= 1'b1;
            O_spi_cs_n  <= 1'b1;
            O_spi_mosi  <= '0;
            O_overrun   <= 1'b0;
`ifdef SPI_MATRIX_TX_CS_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            if (any_pulse && state != S_IDLE)
                O_overrun <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (any_pulse) begin
                        shreg       <= I_data_flat;
                        O_tx_finish <= 1'b0;
                        bcnt        <= '0;
                        last        <= 1'b0;
`ifdef SPI_MATRIX_TX_CS_TIMEOUT_EN
                        idle_cnt    <= '0;
`endif
                        unique case (kind)
                            IMAGE: begin
                                state      <= S_GAP;
                                gcnt       <= IMG_GAP;
                                O_spi_cs_n <= 1'b1;
                            end
                            COLUMN: begin
                                state      <= S_GAP;
                                gcnt       <= COL_GAP;
                                O_spi_cs_n <= 1'b1;
                            end
                            default: begin
                                state      <= S_SHIFT;
                                O_spi_cs_n <= 1'b0;
                                O_spi_mosi <= in_msb;
                            end
                        endcase
                    end
`ifdef SPI_MATRIX_TX_CS_TIMEOUT_EN
                    else if (!O_spi_cs_n) begin
                        idle_cnt <= idle_cnt + 1'b1;
                        if (idle_cnt == TO_LAST)
                            O_spi_cs_n <= 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (gcnt <= GW'(1)) begin
                        state      <= S_SHIFT;
                        gcnt       <= '0;
                        O_spi_cs_n <= 1'b0;
                        O_spi_mosi <= sh_msb;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                S_SHIFT: begin
                    // last is latched at the rising edge so the final high phase completes
                    if (rise_tick)
                        last <= (bcnt == LAST_BIT);
                    if (fall_tick) begin
                        if (last) begin
                            state       <= S_IDLE;
                            O_tx_finish <= 1'b1;
                            O_spi_mosi  <= '0;
                            bcnt        <= '0;
                            last        <= 1'b0;
                        end else begin
                            bcnt       <= bcnt + 1'b1;
                            shreg      <= shl;
                            O_spi_mosi <= nxt_msb;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_matrix_tx.sv
// Directed bench for spi_matrix_tx: vector table plus reset/back-to-back/idle sequences.
module tb_spi_matrix_tx;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           nd, nc, ni;
    logic [N*W-1:0] data;
    logic           fin, sclk, cs_n, ovr;
    logic [N-1:0]   mosi;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    spi_matrix_tx #(
        .SPI_CHANNEL_NUMBER(N),
        .DATA_WIDTH        (W),
        .CLK_DIV           (2),
        .COLUMN_GAP        (8),
        .IMAGE_GAP         (32),
        .CS_TIMEOUT_CYCLES (TO)
    ) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_next_data  (nd),
        .I_next_column(nc),
        .I_next_image (ni),
        .I_data_flat  (data),
        .O_tx_finish  (fin),
        .O_spi_sclk   (sclk),
        .O_spi_cs_n   (cs_n),
        .O_spi_mosi   (mosi),
        .O_overrun    (ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        img;
        logic        col;
        logic        dat;
        logic [31:0] d;
        int          dup_at;
        int          gap;
        int          rise1;
        int          fin_at;
        logic [31:0] samp;
        logic        ovr;
    } vec_t;

    vec_t vecs[5];

`ifdef SPI_MATRIX_TX_CS_TIMEOUT_EN
    localparam int CS_REL = TO;
`else
    localparam int CS_REL = 40;
`endif

    initial begin
        int hi_cnt, cs_bad, rises, r1, fk, k2, kc;
        logic seen_low, prev;
        logic [31:0] samp;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h00FF3CA5, 0, 0,  3,  33, 32'h00FF3CA5, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h12345678, 0, 8,  11, 41, 32'h12345678, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h8001C37E, 0, 32, 35, 65, 32'h8001C37E, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h00FF3CA5, 5, 0,  3,  33, 32'h00FF3CA5, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h5AA55AA5, 0, 0,  3,  33, 32'h5AA55AA5, 1'b1};

        rst = 1'b1; nd = 0; nc = 0; ni = 0; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst finish", 32'(fin), 1);
        chk("rst cs_n", 32'(cs_n), 1);
        chk("rst sclk", 32'(sclk), 0);
        chk("rst mosi", 32'(mosi), 0);
        chk("rst overrun", 32'(ovr), 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            ni = vecs[v].img; nc = vecs[v].col; nd = vecs[v].dat;
            data = vecs[v].d;
            @(posedge clk); #1;
            ni = 0; nc = 0; nd = 0;
            hi_cnt = 0; cs_bad = 0; rises = 0; r1 = -1; fk = -1;
            seen_low = 0; prev = 0; samp = '0;
            for (int k = 1; k <= 200; k++) begin
                @(negedge clk);
                if (k == vecs[v].dup_at) nd = 1'b1;
                if (k == vecs[v].dup_at + 1) nd = 1'b0;
                if (fin) begin
                    fk = k;
                    break;
                end
                if (!seen_low) begin
                    if (cs_n) hi_cnt++;
                    else seen_low = 1'b1;
                end else if (cs_n) cs_bad++;
                if (sclk && !prev) begin
                    rises++;
                    if (r1 < 0) r1 = k;
                    for (int c = 0; c < N; c++)
                        samp[c*W +: W] = {samp[c*W +: W-1], mosi[c]};
                end
                prev = sclk;
                @(posedge clk);
            end
            nd = 1'b0;
            chk($sformatf("v%0d cs_gap", v), hi_cnt, vecs[v].gap);
            chk($sformatf("v%0d cs_glitch", v), cs_bad, 0);
            chk($sformatf("v%0d first_rise", v), r1, vecs[v].rise1);
            chk($sformatf("v%0d rises", v), rises, W);
            chk($sformatf("v%0d finish_at", v), fk, vecs[v].fin_at);
            chk($sformatf("v%0d samples", v), samp, vecs[v].samp);
            chk($sformatf("v%0d overrun", v), 32'(ovr), 32'(vecs[v].ovr));
        end

        // reset during a transfer
        @(posedge clk); #1;
        nd = 1'b1; data = 32'hDEADBEEF;
        @(posedge clk); #1;
        nd = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst cs_n", 32'(cs_n), 1);
        chk("midrst sclk", 32'(sclk), 0);
        chk("midrst mosi", 32'(mosi), 0);
        chk("midrst finish", 32'(fin), 1);
        chk("midrst overrun", 32'(ovr), 0);
        rst = 1'b0;

        // pulse in the cycle finish rises is accepted
        @(posedge clk); #1;
        nd = 1'b1; data = 32'h11223344;
        @(posedge clk); #1;
        nd = 1'b0;
        fk = 1;
        @(negedge clk);
        while (!fin && fk < 100) begin
            @(negedge clk);
            fk++;
        end
        chk("b2b first finish", fk, 33);
        nd = 1'b1; data = 32'hCAFEF00D;
        @(negedge clk);
        nd = 1'b0;
        chk("b2b accepted", 32'(fin), 0);
        k2 = 1;
        while (!fin && k2 < 100) begin
            @(negedge clk);
            k2++;
        end
        chk("b2b second finish", k2, 33);
        chk("b2b overrun", 32'(ovr), 0);

        // idle CS behaviour after the last byte
        kc = 0;
        while (!cs_n && kc < 40) begin
            @(negedge clk);
            kc++;
        end
        chk("idle cs release", kc, CS_REL);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
